sonar_time_format: RTL and testbench
====================================

SONAR_TIME_FORMAT -- requirements
Module: sonar_time_format

Interface
REQ-001 Parameter COUNT_W, default 64: width of tick counter, reference register and time outputs.
REQ-002 Parameter TAG_W, default 8: width of the command label carried to the output.
REQ-003 Parameter CLK_PERIOD, default 10: clock period in time units; scales tick values to time values.
REQ-004 The block SHALL have one clock and an asynchronous, active-high reset, with ports as below.
REQ-005 clk  in  1  sole clock; all state updates on rising edge.
REQ-006 rst  in  1  asynchronous, active-high reset.
REQ-007 cmd_valid  in  1  command present.
REQ-008 cmd_ready  out  1  command accepted when cmd_valid && cmd_ready at a rising edge.
REQ-009 cmd_op  in  2  opcode: 0 INIT, 1 PRINT, 2 DELTA, 3 reserved.
REQ-010 cmd_tag  in  TAG_W  label, returned unchanged with the result.
REQ-011 ts_valid  out  1  result present.
REQ-012 ts_ready  in  1  downstream accepts result.
REQ-013 ts_ticks  out  COUNT_W  result in clock ticks.
REQ-014 ts_time  out  COUNT_W  ts_ticks * CLK_PERIOD, truncated to COUNT_W bits.
REQ-015 ts_is_delta  out  1  1 = DELTA result, 0 = PRINT result.
REQ-016 ts_tag  out  TAG_W  cmd_tag of the originating command.
REQ-017 err  out  1  one-cycle pulse on acceptance of opcode 3.

Function
REQ-018 A free-running tick counter SHALL hold 0 during reset, count up by 1 every cycle afterwards, and wrap from 2^COUNT_W-1 to 0.
REQ-019 cmd_ready SHALL equal (!ts_valid || ts_ready), for every opcode.
REQ-020 Accepted INIT SHALL load the reference register with the counter value of the accept cycle, produce no result and raise no err.
REQ-021 Accepted PRINT SHALL produce a result with ts_ticks = counter value of the accept cycle and ts_is_delta = 0.
REQ-022 Accepted DELTA SHALL produce a result with ts_ticks = (counter - reference) mod 2^COUNT_W, computed on the accept cycle, and ts_is_delta = 1.
REQ-023 DELTA before any INIT SHALL use the reset reference value 0.
REQ-024 Latency: a PRINT/DELTA accepted at edge N SHALL show ts_valid = 1 after edge N, with the result captured at N.
REQ-025 A result SHALL hold stable while ts_valid && !ts_ready; it leaves on ts_valid && ts_ready.
REQ-026 A result retired and a new PRINT/DELTA accepted at the same edge SHALL load the new result with no bubble.
REQ-027 Accepted opcode 3 SHALL pulse err for exactly the next cycle and SHALL change neither the result register nor the reference.
REQ-028 ts_time SHALL be registered together with ts_ticks, so both describe the same result.

Reset
REQ-029 Reset SHALL set counter, reference, ts_ticks, ts_time, ts_tag and ts_is_delta to 0.
REQ-030 Reset SHALL drive ts_valid = 0 and err = 0.
REQ-031 Reset SHALL drive cmd_ready = 1, following the REQ-019 rule.
REQ-032 Reset asserted mid-operation SHALL discard any pending result; commands presented during reset are not accepted.

Structure
REQ-033 A shared package SHALL hold the opcode enum (INIT/PRINT/DELTA/RSVD) and default COUNT_W/TAG_W/CLK_PERIOD constants.
REQ-034 The counter SHALL be one sub-module, sonar_tick_counter (parameter COUNT_W; ports clk, rst, count); all other logic stays in sonar_time_format.

Verification
REQ-035 Release reset at edge 0; PRINT tag 5 accepted when the counter is 20 -> next cycle ts_ticks=20, ts_time=200, ts_tag=5, ts_is_delta=0.
REQ-036 INIT when the counter is 100, then DELTA when it is 137 -> ts_ticks=37, ts_time=370, ts_is_delta=1.
REQ-037 COUNT_W=8: INIT when the counter is 250, DELTA when it is 4 (after wrap) -> ts_ticks=10.
REQ-038 Hold ts_ready=0 for 5 cycles after a result -> result stable and cmd_ready=0 throughout; ts_ready=1 with a new PRINT -> back-to-back results, no bubble.
REQ-039 Opcode 3 accepted -> err=1 for exactly one cycle, ts_valid stays 0, and a later DELTA uses the unchanged reference.
REQ-040 Assert rst while ts_valid=1 -> ts_valid=0 and all outputs 0; after release, a DELTA before any INIT returns the raw counter value.

Source files
------------

// File: rtl/sonar_time_format_pkg.sv
// Shared opcode encoding and default sizing for the sonar timestamp formatter.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package sonar_time_format_pkg;

  // Command opcodes carried on cmd_op.
  typedef enum logic [1:0] {
    OP_INIT  = 2'd0,  // capture current tick count as the reference
    OP_PRINT = 2'd1,  // report absolute tick count
    OP_DELTA = 2'd2,  // report ticks elapsed since the reference
    OP_RSVD  = 2'd3   // reserved: flagged on err, otherwise ignored
  } sonar_op_e;

  localparam int DEF_COUNT_W    = 64;
  localparam int DEF_TAG_W      = 8;
  localparam int DEF_CLK_PERIOD = 10;

endpackage

// File: rtl/sonar_tick_counter.sv
// Free-running tick counter; wraps from all-ones back to zero.
// Latency: count reflects the number of rising edges since reset release.
// Backpressure: none, counts every cycle.
//
// Ports:
//   clk   - sole clock
//   rst   - asynchronous active-high reset, holds count at 0
//   count - current tick value
module sonar_tick_counter
  import sonar_time_format_pkg::*;
#(
  parameter int COUNT_W = DEF_COUNT_W
) (
  input  logic               clk,
  input  logic               rst,
  output logic [COUNT_W-1:0] count
);

  logic [COUNT_W-1:0] count_q;
  logic [COUNT_W-1:0] count_d;

  // Natural modular wrap of the adder gives the 2^COUNT_W rollover.
  assign count_d = count_q + COUNT_W'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/sonar_time_format.sv
// Timestamp formatter: INIT captures a reference, PRINT/DELTA emit tick and time results.
// Latency: result registered one cycle after command acceptance; err pulses the cycle after.
// Backpressure: single-entry result register; cmd_ready = !ts_valid || ts_ready for all opcodes.
//
// Ports:
//   clk, rst                    - clock and asynchronous active-high reset
//   cmd_valid/cmd_ready         - command handshake; cmd_op opcode, cmd_tag label
//   ts_valid/ts_ready           - result handshake
//   ts_ticks, ts_time           - result in ticks and in time units (ticks * CLK_PERIOD)
//   ts_is_delta, ts_tag         - result kind and the originating command's label
//   err                         - one-cycle pulse after a reserved opcode is accepted
module sonar_time_format
  import sonar_time_format_pkg::*;
#(
  parameter int COUNT_W    = DEF_COUNT_W,
  parameter int TAG_W      = DEF_TAG_W,
  parameter int CLK_PERIOD = DEF_CLK_PERIOD
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [1:0]         cmd_op,
  input  logic [TAG_W-1:0]   cmd_tag,
  output logic               ts_valid,
  input  logic               ts_ready,
  output logic [COUNT_W-1:0] ts_ticks,
  output logic [COUNT_W-1:0] ts_time,
  output logic               ts_is_delta,
  output logic [TAG_W-1:0]   ts_tag,
  output logic               err
);

  localparam logic [COUNT_W-1:0] PERIOD = COUNT_W'(CLK_PERIOD);

  logic [COUNT_W-1:0] count;

  logic [COUNT_W-1:0] ref_q,   ref_d;
  logic [COUNT_W-1:0] ticks_q, ticks_d;
  logic [COUNT_W-1:0] time_q,  time_d;
  logic [TAG_W-1:0]   tag_q,   tag_d;
  logic               delta_q, delta_d;
  logic               valid_q, valid_d;
  logic               err_q,   err_d;

  logic               accept;
  logic [COUNT_W-1:0] res_ticks;
  sonar_op_e          op;

  sonar_tick_counter #(
    .COUNT_W (COUNT_W)
  ) u_tick_counter (
    .clk   (clk),
    .rst   (rst),
    .count (count)
  );

  assign op        = sonar_op_e'(cmd_op);
  assign cmd_ready = !valid_q || ts_ready;
  assign accept    = cmd_valid && cmd_ready;

  always_comb begin
    ref_d     = ref_q;
    ticks_d   = ticks_q;
    time_d    = time_q;
    tag_d     = tag_q;
    delta_d   = delta_q;
    valid_d   = valid_q;
    err_d     = 1'b0;
    res_ticks = count;

    // Retire first; a same-edge PRINT/DELTA below overrides, giving no bubble.
    if (valid_q && ts_ready) begin
      valid_d = 1'b0;
    end

    if (accept) begin
      case (op)
        OP_INIT: begin
          ref_d = count;
        end
        OP_PRINT, OP_DELTA: begin
          // Subtraction wraps mod 2^COUNT_W, so a counter rollover between
          // INIT and DELTA still yields the true elapsed tick count.
          res_ticks = (op == OP_DELTA) ? (count - ref_q) : count;
          valid_d   = 1'b1;
          ticks_d   = res_ticks;
          // Time is captured with the ticks so both always describe one result.
          time_d    = res_ticks * PERIOD;
          tag_d     = cmd_tag;
          delta_d   = (op == OP_DELTA);
        end
        OP_RSVD: begin
          err_d = 1'b1;
        end
        default: begin
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ref_q   <= '0;
      ticks_q <= '0;
      time_q  <= '0;
      tag_q   <= '0;
      delta_q <= 1'b0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      ref_q   <= ref_d;
      ticks_q <= ticks_d;
      time_q  <= time_d;
      tag_q   <= tag_d;
      delta_q <= delta_d;
      valid_q <= valid_d;
      err_q   <= err_d;
    end
  end

  assign ts_valid    = valid_q;
  assign ts_ticks    = ticks_q;
  assign ts_time     = time_q;
  assign ts_is_delta = delta_q;
  assign ts_tag      = tag_q;
  assign err         = err_q;

endmodule

// File: tb/tb_sonar_time_format.sv
// Self-checking bench for sonar_time_format: directed scenarios plus randomized
// traffic against a transaction-level model (absolute cycle count, reference
// snapshot, single pending result).
module tb_sonar_time_format;

  logic        clk = 1'b0;
  logic        rst = 1'b1;

  // 64-bit instance
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [1:0]  cmd_op = 2'd0;
  logic [7:0]  cmd_tag = 8'd0;
  logic        ts_valid;
  logic        ts_ready = 1'b1;
  logic [63:0] ts_ticks;
  logic [63:0] ts_time;
  logic        ts_is_delta;
  logic [7:0]  ts_tag;
  logic        err;

  // 8-bit instance for wrap-around behaviour
  logic        c8_valid = 1'b0;
  logic        c8_ready;
  logic [1:0]  c8_op = 2'd0;
  logic [7:0]  c8_tag = 8'd0;
  logic        r8_valid;
  logic [7:0]  r8_ticks;
  logic [7:0]  r8_time;
  logic        r8_delta;
  logic [7:0]  r8_tag;
  logic        r8_err;

  int pass_cnt  = 0;
  int total_cnt = 0;

  // Cycles elapsed since reset release: the value the DUT counter should hold.
  logic [63:0] cyc;

  always #5 clk = ~clk;

  always @(posedge clk or posedge rst) begin
    if (rst) cyc <= '0;
    else     cyc <= cyc + 64'd1;
  end

  sonar_time_format #(.COUNT_W(64), .TAG_W(8), .CLK_PERIOD(10)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_tag(cmd_tag),
    .ts_valid(ts_valid), .ts_ready(ts_ready), .ts_ticks(ts_ticks), .ts_time(ts_time),
    .ts_is_delta(ts_is_delta), .ts_tag(ts_tag), .err(err)
  );

  sonar_time_format #(.COUNT_W(8), .TAG_W(8), .CLK_PERIOD(10)) dut8 (
    .clk(clk), .rst(rst),
    .cmd_valid(c8_valid), .cmd_ready(c8_ready), .cmd_op(c8_op), .cmd_tag(c8_tag),
    .ts_valid(r8_valid), .ts_ready(1'b1), .ts_ticks(r8_ticks), .ts_time(r8_time),
    .ts_is_delta(r8_delta), .ts_tag(r8_tag), .err(r8_err)
  );

  task automatic drive(input logic v, input logic [1:0] op, input logic [7:0] tag, input logic rdy);
    cmd_valid = v; cmd_op = op; cmd_tag = tag; ts_ready = rdy;
  endtask

  task automatic idle();
    drive(1'b0, 2'd0, 8'd0, 1'b1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    idle();
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // Advance to the negedge where the counter equals target (bounded).
  task automatic wait_cyc(input logic [63:0] target);
    int n = 0;
    while (cyc != target && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (cyc != target) begin
      total_cnt++;
      $display("FAIL wait_cyc timeout: counter at %0d, wanted %0d", cyc, target);
    end
  endtask

  task automatic wait_lo8(input logic [7:0] target);
    int n = 0;
    while (cyc[7:0] != target && n < 600) begin
      @(negedge clk);
      n++;
    end
    if (cyc[7:0] != target) begin
      total_cnt++;
      $display("FAIL wait_lo8 timeout: low byte %0d, wanted %0d", cyc[7:0], target);
    end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    total_cnt++; if (ts_valid !== 1'b0) $display("FAIL rst_valid got %b want 0", ts_valid); else pass_cnt++;
    total_cnt++; if (err !== 1'b0) $display("FAIL rst_err got %b want 0", err); else pass_cnt++;
    total_cnt++; if (cmd_ready !== 1'b1) $display("FAIL rst_cmd_ready got %b want 1", cmd_ready); else pass_cnt++;
    total_cnt++; if (ts_ticks !== 64'd0) $display("FAIL rst_ticks got %0d want 0", ts_ticks); else pass_cnt++;
    total_cnt++; if (ts_time !== 64'd0) $display("FAIL rst_time got %0d want 0", ts_time); else pass_cnt++;
    total_cnt++; if ({ts_tag, ts_is_delta} !== 9'd0) $display("FAIL rst_tag_delta got %h want 0", {ts_tag, ts_is_delta}); else pass_cnt++;
    total_cnt++; if ({r8_valid, r8_ticks, r8_err} !== 10'd0) $display("FAIL rst8 got %h want 0", {r8_valid, r8_ticks, r8_err}); else pass_cnt++;
    rst = 1'b0;
  endtask

  task automatic test_print();
    do_reset();
    wait_cyc(64'd20);
    drive(1'b1, 2'd1, 8'd5, 1'b1);
    @(negedge clk);
    total_cnt++; if (ts_valid !== 1'b1) $display("FAIL print_valid got %b want 1", ts_valid); else pass_cnt++;
    total_cnt++; if (ts_ticks !== 64'd20) $display("FAIL print_ticks got %0d want 20", ts_ticks); else pass_cnt++;
    total_cnt++; if (ts_time !== 64'd200) $display("FAIL print_time got %0d want 200", ts_time); else pass_cnt++;
    total_cnt++; if (ts_tag !== 8'd5) $display("FAIL print_tag got %0d want 5", ts_tag); else pass_cnt++;
    total_cnt++; if (ts_is_delta !== 1'b0) $display("FAIL print_is_delta got %b want 0", ts_is_delta); else pass_cnt++;
    idle();
    @(negedge clk);
    total_cnt++; if (ts_valid !== 1'b0) $display("FAIL print_retire got %b want 0", ts_valid); else pass_cnt++;
  endtask

  task automatic test_delta();
    wait_cyc(64'd100);
    drive(1'b1, 2'd0, 8'd0, 1'b1);
    @(negedge clk);
    total_cnt++; if ({ts_valid, err} !== 2'b00) $display("FAIL init_quiet got %b want 00", {ts_valid, err}); else pass_cnt++;
    idle();
    wait_cyc(64'd137);
    drive(1'b1, 2'd2, 8'd7, 1'b1);
    @(negedge clk);
    total_cnt++; if (ts_ticks !== 64'd37) $display("FAIL delta_ticks got %0d want 37", ts_ticks); else pass_cnt++;
    total_cnt++; if (ts_time !== 64'd370) $display("FAIL delta_time got %0d want 370", ts_time); else pass_cnt++;
    total_cnt++; if ({ts_valid, ts_is_delta, ts_tag} !== {1'b1, 1'b1, 8'd7}) $display("FAIL delta_flags got %h want %h", {ts_valid, ts_is_delta, ts_tag}, {1'b1, 1'b1, 8'd7}); else pass_cnt++;
    idle();
  endtask

  task automatic test_wrap8();
    wait_lo8(8'd250);
    c8_valid = 1'b1; c8_op = 2'd0; c8_tag = 8'd0;
    @(negedge clk);
    c8_valid = 1'b0;
    wait_lo8(8'd4);
    c8_valid = 1'b1; c8_op = 2'd2; c8_tag = 8'd3;
    @(negedge clk);
    c8_valid = 1'b0;
    total_cnt++; if (r8_ticks !== 8'd10) $display("FAIL wrap8_ticks got %0d want 10", r8_ticks); else pass_cnt++;
    total_cnt++; if (r8_time !== 8'd100) $display("FAIL wrap8_time got %0d want 100", r8_time); else pass_cnt++;
    total_cnt++; if ({r8_valid, r8_delta, r8_tag} !== {1'b1, 1'b1, 8'd3}) $display("FAIL wrap8_flags got %h want %h", {r8_valid, r8_delta, r8_tag}, {1'b1, 1'b1, 8'd3}); else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    logic [63:0] c0, c1, c2;
    @(negedge clk);
    drive(1'b1, 2'd1, 8'd1, 1'b0);
    c0 = cyc;
    @(negedge clk);
    drive(1'b1, 2'd1, 8'd9, 1'b0);
    for (int i = 0; i < 5; i++) begin
      #1;
      total_cnt++; if ({ts_valid, cmd_ready} !== 2'b10) $display("FAIL stall_hs[%0d] got %b want 10", i, {ts_valid, cmd_ready}); else pass_cnt++;
      total_cnt++; if (ts_ticks !== c0 || ts_tag !== 8'd1) $display("FAIL stall_hold[%0d] got %0d/%0d want %0d/1", i, ts_ticks, ts_tag, c0); else pass_cnt++;
      @(negedge clk);
    end
    drive(1'b1, 2'd1, 8'd9, 1'b1);
    c1 = cyc;
    @(negedge clk);
    total_cnt++; if ({ts_valid, ts_tag} !== {1'b1, 8'd9} || ts_ticks !== c1) $display("FAIL b2b_first got %b/%0d/%0d want 1/9/%0d", ts_valid, ts_tag, ts_ticks, c1); else pass_cnt++;
    drive(1'b1, 2'd1, 8'd10, 1'b1);
    c2 = cyc;
    @(negedge clk);
    total_cnt++; if ({ts_valid, ts_tag} !== {1'b1, 8'd10} || ts_ticks !== c2) $display("FAIL b2b_second got %b/%0d/%0d want 1/10/%0d", ts_valid, ts_tag, ts_ticks, c2); else pass_cnt++;
    idle();
    @(negedge clk);
    total_cnt++; if (ts_valid !== 1'b0) $display("FAIL b2b_drain got %b want 0", ts_valid); else pass_cnt++;
  endtask

  task automatic test_rsvd();
    logic [63:0] c0, c1;
    drive(1'b1, 2'd0, 8'd0, 1'b1);
    c0 = cyc;
    @(negedge clk);
    drive(1'b1, 2'd3, 8'd0, 1'b1);
    @(negedge clk);
    idle();
    total_cnt++; if ({err, ts_valid} !== 2'b10) $display("FAIL rsvd_pulse got %b want 10", {err, ts_valid}); else pass_cnt++;
    @(negedge clk);
    total_cnt++; if ({err, ts_valid} !== 2'b00) $display("FAIL rsvd_end got %b want 00", {err, ts_valid}); else pass_cnt++;
    repeat (3) @(negedge clk);
    drive(1'b1, 2'd2, 8'd4, 1'b1);
    c1 = cyc;
    @(negedge clk);
    idle();
    total_cnt++; if (ts_ticks !== c1 - c0 || ts_is_delta !== 1'b1) $display("FAIL rsvd_ref got %0d/%b want %0d/1", ts_ticks, ts_is_delta, c1 - c0); else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    logic [63:0] c;
    drive(1'b1, 2'd1, 8'd6, 1'b0);
    @(negedge clk);
    drive(1'b0, 2'd0, 8'd0, 1'b0);
    total_cnt++; if (ts_valid !== 1'b1) $display("FAIL mid_pre got %b want 1", ts_valid); else pass_cnt++;
    rst = 1'b1;
    drive(1'b1, 2'd1, 8'd8, 1'b1);
    #1;
    total_cnt++; if ({ts_valid, err, cmd_ready} !== 3'b001) $display("FAIL mid_hs got %b want 001", {ts_valid, err, cmd_ready}); else pass_cnt++;
    total_cnt++; if ({ts_ticks, ts_time, ts_tag, ts_is_delta} !== '0) $display("FAIL mid_data got %0d/%0d/%0d/%b want zeros", ts_ticks, ts_time, ts_tag, ts_is_delta); else pass_cnt++;
    repeat (2) @(negedge clk);
    total_cnt++; if (ts_valid !== 1'b0) $display("FAIL mid_no_accept got %b want 0", ts_valid); else pass_cnt++;
    idle();
    rst = 1'b0;
    repeat (3) @(negedge clk);
    drive(1'b1, 2'd2, 8'd2, 1'b1);
    c = cyc;
    @(negedge clk);
    idle();
    total_cnt++; if (ts_ticks !== c || ts_time !== c * 64'd10 || ts_is_delta !== 1'b1) $display("FAIL mid_delta got %0d/%0d want %0d/%0d", ts_ticks, ts_time, c, c * 64'd10); else pass_cnt++;
  endtask

  task automatic test_random();
    logic        m_valid = 1'b0, m_err = 1'b0, m_delta = 1'b0;
    logic [63:0] m_ticks = '0, m_ref = '0;
    logic [7:0]  m_tag = '0;
    logic        v, rdy, acc, exp_rdy;
    logic [1:0]  op;
    logic [7:0]  tag;
    int          bad = 0;
    do_reset();
    for (int i = 0; i < 300; i++) begin
      v   = 1'($urandom_range(0, 1));
      op  = 2'($urandom_range(0, 3));
      tag = 8'($urandom);
      rdy = ($urandom_range(0, 3) != 0);
      drive(v, op, tag, rdy);
      exp_rdy = !m_valid || rdy;
      #1;
      total_cnt++; if (cmd_ready !== exp_rdy) begin $display("FAIL rand_ready[%0d] got %b want %b", i, cmd_ready, exp_rdy); bad++; end else pass_cnt++;
      acc = v && exp_rdy;
      m_err = acc && (op == 2'd3);
      if (m_valid && rdy) m_valid = 1'b0;
      if (acc && op == 2'd0) m_ref = cyc;
      if (acc && (op == 2'd1 || op == 2'd2)) begin
        m_valid = 1'b1;
        m_ticks = (op == 2'd2) ? cyc - m_ref : cyc;
        m_delta = (op == 2'd2);
        m_tag   = tag;
      end
      @(negedge clk);
      total_cnt++; if ({ts_valid, err} !== {m_valid, m_err}) begin $display("FAIL rand_hs[%0d] got %b want %b", i, {ts_valid, err}, {m_valid, m_err}); bad++; end else pass_cnt++;
      total_cnt++; if (ts_ticks !== m_ticks || ts_time !== m_ticks * 64'd10) begin $display("FAIL rand_res[%0d] got %0d/%0d want %0d/%0d", i, ts_ticks, ts_time, m_ticks, m_ticks * 64'd10); bad++; end else pass_cnt++;
      total_cnt++; if ({ts_tag, ts_is_delta} !== {m_tag, m_delta}) begin $display("FAIL rand_tag[%0d] got %h want %h", i, {ts_tag, ts_is_delta}, {m_tag, m_delta}); bad++; end else pass_cnt++;
      if (bad > 10) break;
    end
    idle();
  endtask

  initial begin
    idle();
    test_reset();
    test_print();
    test_delta();
    test_wrap8();
    test_back_to_back();
    test_rsvd();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
